// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: round-robin Wishbone B3 classic arbiter, NM masters onto one slave, with hang watchdog
module wb_rr_arbiter #(
  parameter int NM  = 2,
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int TMO = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NM-1:0]    m_cyc_i,
  input  logic [NM-1:0]    m_stb_i,
  input  logic [NM-1:0]    m_we_i,
  input  logic [NM*DW/8-1:0] m_sel_i,
  input  logic [NM*AW-1:0] m_adr_i,
  input  logic [NM*DW-1:0] m_dat_i,
  output logic [DW-1:0]    m_dat_o,
  output logic [NM-1:0]    m_ack_o,
  output logic [NM-1:0]    m_err_o,
  output logic             s_cyc_o,
  output logic             s_stb_o,
  output logic             s_we_o,
  output logic [DW/8-1:0]  s_sel_o,
  output logic [AW-1:0]    s_adr_o,
  output logic [DW-1:0]    s_dat_o,
  input  logic [DW-1:0]    s_dat_i,
  input  logic             s_ack_i,
  input  logic             s_err_i,
  output logic [NM-1:0]    gnt_o
);
  localparam int SW = DW / 8;
  localparam int LW = $clog2(NM);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] TERR = 2'd2;
  localparam logic [15:0] TMO_W = 16'(TMO);

  logic [1:0]    state_q, state_d;
  logic [NM-1:0] gnt_q, gnt_d;
  logic [LW-1:0] last_q, last_d;
  logic [15:0]   wdog_q, wdog_d;
  logic [LW-1:0] idx, pick_idx;
  logic          busy, stall, g_cyc;

  assign busy    = state_q == BUSY;
  assign g_cyc   = |(m_cyc_i & gnt_q);
  assign stall   = s_stb_o && !s_ack_i && !s_err_i;
  assign gnt_o   = gnt_q;
  assign m_dat_o = s_dat_i;
  assign m_ack_o = busy ? gnt_q & {NM{s_ack_i}} : '0;
  assign m_err_o = ((busy && s_err_i) || state_q == TERR) ? gnt_q : '0;

  // first requester after the last winner; scanning backwards lets the nearest one overwrite
  always_comb begin
    idx = '0;
    pick_idx = last_q;
    for (int i = NM; i >= 1; i--) begin
      idx = LW'((int'(last_q) + i) % NM);
      if (m_cyc_i[idx]) pick_idx = idx;
    end
  end

  // slave side follows the granted master only while BUSY; idle and forced-error cycles drive zeros
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = '0;
    s_adr_o = '0;
    s_dat_o = '0;
    for (int k = 0; k < NM; k++) begin
      if (busy && gnt_q[k]) begin
        s_cyc_o = m_cyc_i[k];
        s_stb_o = m_stb_i[k];
        s_we_o  = m_we_i[k];
        s_sel_o = m_sel_i[k*SW +: SW];
        s_adr_o = m_adr_i[k*AW +: AW];
        s_dat_o = m_dat_i[k*DW +: DW];
      end
    end
  end

  // FSM: arbitrate in IDLE, hold grant for the whole cycle, bail out through TERR on a stalled slave
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    wdog_d  = stall ? wdog_q + 16'd1 : '0;
    if (state_q == IDLE && |m_cyc_i) begin
      state_d = BUSY;
      gnt_d   = NM'(1) << pick_idx;
      last_d  = pick_idx;
    end else if (busy && !g_cyc) begin
      state_d = IDLE;
      gnt_d   = '0;
    end else if (busy && stall && wdog_q + 16'd1 == TMO_W) begin
      state_d = TERR;
    end else if (state_q == TERR) begin
      state_d = IDLE;
      gnt_d   = '0;
    end
  end

  // state registers; reset points last at NM-1 so master 0 wins first
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      last_q  <= LW'(NM - 1);
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      wdog_q  <= wdog_d;
    end
  end
endmodule
